// File: rtl/fx_match_pipe.sv
// Fixed-point format converter: rounds or pads to the output format, then saturates or wraps.
// Optional overflow event counter on o_ovf_cnt when FX_MATCH_PIPE_OVF_CNT_EN is defined.
module fx_match_pipe #(
    parameter int IN_W       = 16,
    parameter int IN_FRAC    = 8,
    parameter int OUT_W      = 10,
    parameter int OUT_FRAC   = 4,
    parameter int ROUND_MODE = 1,
    parameter int SAT_EN     = 1,
    parameter int DELAY      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_clr_sticky,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf,
    output logic             o_ovf_sticky
`ifdef FX_MATCH_PIPE_OVF_CNT_EN
    ,
    output logic [15:0]      o_ovf_cnt
`endif
);

    localparam int D      = IN_FRAC - OUT_FRAC;
    // One guard bit above the quantized range keeps the rounding carry.
    localparam int Q_W    = IN_W - D + 1;
    localparam int STAGES = 1 + DELAY;

    logic [STAGES:0]         vld_pipe;
    logic signed [Q_W-1:0]   q_nxt;
    logic signed [Q_W-1:0]   s1_q;
    logic signed [OUT_W-1:0] ovf_data;
    logic                    ovf_nxt;
    logic [OUT_W-1:0]        d_pipe [DELAY:0];
    logic [DELAY:0]          ovf_pipe;
    logic                    ovf_hit;

    // Stage 1: quantization
    generate
        if (D > 0) begin : g_drop
            logic [Q_W-1:0] fl;
            logic [D-1:0]   frac;
            logic [D-1:0]   half;
            logic           inc;

            always_comb begin
                fl      = {i_data[IN_W-1], i_data[IN_W-1:D]};
                frac    = i_data[D-1:0];
                half    = '0;
                half[D-1] = 1'b1;
                inc     = 1'b0;
                case (ROUND_MODE)
                    0:       inc = 1'b0;
                    2:       inc = (frac > half) || ((frac == half) && fl[0]);
                    default: inc = (frac >= half);
                endcase
                q_nxt = $signed(fl + {{(Q_W-1){1'b0}}, inc});
            end
        end else begin : g_pad
            localparam int SH = -D;

            always_comb begin
                q_nxt = $signed({{(SH+1){i_data[IN_W-1]}}, i_data}) <<< SH;
            end
        end
    endgenerate

    // Stage 2: range check, clamp or wrap
    generate
        if (OUT_W >= Q_W) begin : g_pass
            always_comb begin
                ovf_nxt  = 1'b0;
                ovf_data = OUT_W'(s1_q);
            end
        end else begin : g_ovf
            logic [Q_W-OUT_W:0] top;

            always_comb begin
                top      = s1_q[Q_W-1:OUT_W-1];
                ovf_nxt  = !((&top) || !(|top));
                ovf_data = s1_q[OUT_W-1:0];
                if (ovf_nxt && (SAT_EN != 0))
                    ovf_data = s1_q[Q_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:0], i_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s1_q <= '0;
        else if (i_valid) s1_q <= q_nxt;
    end

    // Each data stage loads only when the valid entering it is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DELAY; k++) d_pipe[k] <= '0;
            ovf_pipe <= '0;
        end else begin
            if (vld_pipe[0]) begin
                d_pipe[0]   <= ovf_data;
                ovf_pipe[0] <= ovf_nxt;
            end
            for (int k = 1; k <= DELAY; k++) begin
                if (vld_pipe[k]) begin
                    d_pipe[k]   <= d_pipe[k-1];
                    ovf_pipe[k] <= ovf_pipe[k-1];
                end
            end
        end
    end

    assign o_valid = vld_pipe[STAGES];
    assign o_data  = d_pipe[DELAY];
    assign o_ovf   = ovf_pipe[DELAY];
    assign ovf_hit = o_valid & o_ovf;

    // Set beats clear when both land on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_ovf_sticky <= 1'b0;
        else        o_ovf_sticky <= ovf_hit | (o_ovf_sticky & ~i_clr_sticky);
    end

`ifdef FX_MATCH_PIPE_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         o_ovf_cnt <= '0;
        else if (i_clr_sticky)              o_ovf_cnt <= '0;
        else if (ovf_hit && ~&o_ovf_cnt)    o_ovf_cnt <= o_ovf_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fx_match_pipe.sv
// Directed bench for fx_match_pipe; four instances cover round modes 0/1/2 and wrap.
module tb_fx_match_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_clr_sticky;
    logic        ov [4];
    logic        oo [4];
    logic        os [4];
    logic [9:0]  od [4];
`ifdef FX_MATCH_PIPE_OVF_CNT_EN
    logic [15:0] oc [4];
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // 0: half-up sat, 1: floor sat, 2: half-even sat, 3: half-up wrap
    for (genvar g = 0; g < 4; g++) begin : g_dut
        fx_match_pipe #(
            .ROUND_MODE((g == 1) ? 0 : ((g == 2) ? 2 : 1)),
            .SAT_EN    ((g == 3) ? 0 : 1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_valid     (i_valid),
            .i_data      (i_data),
            .i_clr_sticky(i_clr_sticky),
            .o_valid     (ov[g]),
            .o_data      (od[g]),
            .o_ovf       (oo[g]),
            .o_ovf_sticky(os[g])
`ifdef FX_MATCH_PIPE_OVF_CNT_EN
            ,
            .o_ovf_cnt   (oc[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the 4th rising edge.
    task automatic send_one(input logic [15:0] d);
        i_data  = d;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat;
        int stale;

        rst_n        = 1'b0;
        i_valid      = 1'b0;
        i_data       = '0;
        i_clr_sticky = 1'b0;
        #3;
        chk("rst_valid",  32'(ov[0]), 32'd0);
        chk("rst_data",   32'(od[0]), 32'd0);
        chk("rst_ovf",    32'(oo[0]), 32'd0);
        chk("rst_sticky", 32'(os[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rounding: 0x0128 = 18.5 LSBs, 0x0138 = 19.5 LSBs
        send_one(16'h0128);
        chk("rnd128_valid", 32'(ov[0]), 32'd1);
        chk("rnd128_m1",    32'(od[0]), 32'h013);
        chk("rnd128_m0",    32'(od[1]), 32'h012);
        chk("rnd128_m2",    32'(od[2]), 32'h012);
        chk("rnd128_ovf",   32'(oo[0]), 32'd0);
        send_one(16'h0138);
        chk("rnd138_m2",    32'(od[2]), 32'h014);
        chk("rnd138_m1",    32'(od[0]), 32'h014);
        chk("rnd138_m0",    32'(od[1]), 32'h013);
        chk("rnd138_ovf",   32'(oo[2]), 32'd0);

        // Overflow: +1024 and -1024 output LSBs
        send_one(16'h4000);
        chk("ovfp_sat",      32'(od[0]), 32'h1FF);
        chk("ovfp_sat_flag", 32'(oo[0]), 32'd1);
        chk("ovfp_wrap",     32'(od[3]), 32'h000);
        chk("ovfp_wrap_flg", 32'(oo[3]), 32'd1);
        @(negedge clk);
        chk("sticky_set",    32'(os[0]), 32'd1);
        send_one(16'hC000);
        chk("ovfn_sat",      32'(od[0]), 32'h200);
        chk("ovfn_flag",     32'(oo[0]), 32'd1);
        chk("ovfn_wrap",     32'(od[3]), 32'h000);
        @(negedge clk);
        chk("hold_valid",    32'(ov[0]), 32'd0);
        chk("hold_data",     32'(od[0]), 32'h200);
        chk("hold_ovf",      32'(oo[0]), 32'd1);

        // Rounding carry into the guard bit
        send_one(16'h1FF8);
        chk("carry_m1",      32'(od[0]), 32'h1FF);
        chk("carry_m1_ovf",  32'(oo[0]), 32'd1);
        chk("carry_m0",      32'(od[1]), 32'h1FF);
        chk("carry_m0_ovf",  32'(oo[1]), 32'd0);
        @(negedge clk);

        // Sticky clear, then clear coinciding with a new overflow
        i_clr_sticky = 1'b1;
        @(negedge clk);
        i_clr_sticky = 1'b0;
        chk("sticky_clr",    32'(os[0]), 32'd0);
        send_one(16'h4000);
        i_clr_sticky = 1'b1;
        @(negedge clk);
        i_clr_sticky = 1'b0;
        chk("sticky_setclr", 32'(os[0]), 32'd1);
        repeat (2) @(negedge clk);

        // Latency of a single pulse
        lat     = -1;
        i_data  = 16'h0100;
        i_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            if (ov[0] && lat < 0) lat = k;
        end
        chk("latency", 32'(lat), 32'd4);

        // Eight back-to-back samples: input j*32 -> output 2*j
        for (int t = 0; t < 14; t++) begin
            if (t >= 4 && t <= 11) begin
                chk("b2b_valid", 32'(ov[0]), 32'd1);
                chk("b2b_data",  32'(od[0]), 32'(2 * (t - 4)));
            end else if (t > 11) begin
                chk("b2b_idle",  32'(ov[0]), 32'd0);
            end
            i_valid = (t < 8);
            i_data  = 16'(t * 32);
            @(negedge clk);
        end
        i_valid = 1'b0;
        repeat (2) @(negedge clk);

`ifdef FX_MATCH_PIPE_OVF_CNT_EN
        i_clr_sticky = 1'b1;
        @(negedge clk);
        i_clr_sticky = 1'b0;
        chk("cnt_clr0", 32'(oc[0]), 32'd0);
        for (int j = 0; j < 3; j++) begin
            i_valid = 1'b1;
            i_data  = 16'h4000;
            @(negedge clk);
        end
        i_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("cnt_three", 32'(oc[0]), 32'd3);
        chk("cnt_wrap3", 32'(oc[3]), 32'd3);
        i_clr_sticky = 1'b1;
        @(negedge clk);
        i_clr_sticky = 1'b0;
        chk("cnt_clr", 32'(oc[0]), 32'd0);
`endif

        // Reset in the middle of an overflowing stream
        for (int j = 0; j < 5; j++) begin
            i_valid = 1'b1;
            i_data  = 16'h4000;
            @(negedge clk);
        end
        chk("mid_pre_valid", 32'(ov[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(ov[0]), 32'd0);
        chk("mid_rst_data",   32'(od[0]), 32'd0);
        chk("mid_rst_ovf",    32'(oo[0]), 32'd0);
        chk("mid_rst_sticky", 32'(os[0]), 32'd0);
`ifdef FX_MATCH_PIPE_OVF_CNT_EN
        chk("mid_rst_cnt",    32'(oc[0]), 32'd0);
`endif
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov[0]) stale++;
        end
        chk("mid_no_stale", 32'(stale), 32'd0);
        send_one(16'h0128);
        chk("post_rst_valid", 32'(ov[0]), 32'd1);
        chk("post_rst_data",  32'(od[0]), 32'h013);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
